// File: rtl/aes_reg_master.sv
// rtl/aes_reg_master.sv - register-bus initiator running one AES-128 job (key/text writes, start, poll, result reads)

module aes_reg_master #(
    parameter int POLL_GAP = 4,
    parameter int POLL_MAX = 1024
) (
    input  logic         mclk,
    input  logic         rst_n,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [127:0] job_key,
    input  logic [127:0] job_text,
    input  logic         job_nokey,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [127:0] res_data,
    output logic         res_err,
    output logic         busy,
    output logic         reg_cs,
    output logic [3:0]   reg_addr,
    output logic         reg_wr,
    output logic [31:0]  reg_wdata,
    output logic [3:0]   reg_be,
    input  logic [31:0]  reg_rdata,
    input  logic         reg_ack
);

    localparam int PW = $clog2(POLL_MAX + 1);
    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [PW-1:0] PMAX  = PW'(POLL_MAX);
    localparam logic [GW-1:0] GLAST = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_WKEY, S_WTXT, S_START, S_POLL, S_GAP, S_RRES, S_RESP
    } state_t;

    state_t         state, state_n;
    logic [1:0]     k, k_n;
    logic [PW-1:0]  poll_cnt, poll_cnt_n;
    logic [GW-1:0]  gap_cnt, gap_cnt_n;
    logic [127:0]   key_q, key_n;
    logic [127:0]   text_q, text_n;
    logic [127:0]   res_data_n;
    logic           res_err_n, res_valid_n, job_ready_n;
    logic           reg_cs_n, reg_wr_n;
    logic [3:0]     reg_addr_n;
    logic [31:0]    reg_wdata_n;

    assign busy   = (state != S_IDLE);
    assign reg_be = 4'hF;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            k         <= 2'd0;
            poll_cnt  <= '0;
            gap_cnt   <= '0;
            key_q     <= '0;
            text_q    <= '0;
            res_data  <= '0;
            res_err   <= 1'b0;
            res_valid <= 1'b0;
            job_ready <= 1'b0;
            reg_cs    <= 1'b0;
            reg_addr  <= 4'd0;
            reg_wr    <= 1'b0;
            reg_wdata <= 32'd0;
        end else begin
            state     <= state_n;
            k         <= k_n;
            poll_cnt  <= poll_cnt_n;
            gap_cnt   <= gap_cnt_n;
            key_q     <= key_n;
            text_q    <= text_n;
            res_data  <= res_data_n;
            res_err   <= res_err_n;
            res_valid <= res_valid_n;
            job_ready <= job_ready_n;
            reg_cs    <= reg_cs_n;
            reg_addr  <= reg_addr_n;
            reg_wr    <= reg_wr_n;
            reg_wdata <= reg_wdata_n;
        end
    end

    // Bus states issue when cs is low and finish on the ack edge, which forces a one-cycle cs-low gap.
    always_comb begin
        state_n     = state;
        k_n         = k;
        poll_cnt_n  = poll_cnt;
        gap_cnt_n   = gap_cnt;
        key_n       = key_q;
        text_n      = text_q;
        res_data_n  = res_data;
        res_err_n   = res_err;
        res_valid_n = res_valid;
        reg_cs_n    = reg_cs;
        reg_addr_n  = reg_addr;
        reg_wr_n    = reg_wr;
        reg_wdata_n = reg_wdata;

        case (state)
            S_IDLE: begin
                if (job_valid && job_ready) begin
                    key_n      = job_key;
                    text_n     = job_text;
                    k_n        = 2'd0;
                    res_data_n = '0;
                    res_err_n  = 1'b0;
                    state_n    = job_nokey ? S_WTXT : S_WKEY;
                end
            end
            S_WKEY: begin
                if (!reg_cs) begin
                    reg_cs_n    = 1'b1;
                    reg_addr_n  = 4'd1 + {2'b00, k};
                    reg_wr_n    = 1'b1;
                    reg_wdata_n = key_q[{k, 5'd0} +: 32];
                end else if (reg_ack) begin
                    reg_cs_n = 1'b0;
                    k_n      = k + 1'b1;
                    if (k == 2'd3) state_n = S_WTXT;
                end
            end
            S_WTXT: begin
                if (!reg_cs) begin
                    reg_cs_n    = 1'b1;
                    reg_addr_n  = 4'd5 + {2'b00, k};
                    reg_wr_n    = 1'b1;
                    reg_wdata_n = text_q[{k, 5'd0} +: 32];
                end else if (reg_ack) begin
                    reg_cs_n = 1'b0;
                    k_n      = k + 1'b1;
                    if (k == 2'd3) state_n = S_START;
                end
            end
            S_START: begin
                if (!reg_cs) begin
                    reg_cs_n    = 1'b1;
                    reg_addr_n  = 4'd0;
                    reg_wr_n    = 1'b1;
                    reg_wdata_n = 32'h1;
                end else if (reg_ack) begin
                    reg_cs_n   = 1'b0;
                    poll_cnt_n = '0;
                    state_n    = S_POLL;
                end
            end
            S_POLL: begin
                if (!reg_cs) begin
                    reg_cs_n    = 1'b1;
                    reg_addr_n  = 4'd0;
                    reg_wr_n    = 1'b0;
                    reg_wdata_n = 32'd0;
                end else if (reg_ack) begin
                    reg_cs_n   = 1'b0;
                    poll_cnt_n = poll_cnt + 1'b1;
                    if (!reg_rdata[0]) begin
                        k_n     = 2'd0;
                        state_n = S_RRES;
                    end else if ((poll_cnt + 1'b1) == PMAX) begin
                        res_err_n   = 1'b1;
                        res_data_n  = '0;
                        res_valid_n = 1'b1;
                        state_n     = S_RESP;
                    end else if (POLL_GAP == 0) begin
                        state_n = S_POLL;
                    end else begin
                        gap_cnt_n = '0;
                        state_n   = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == GLAST) state_n = S_POLL;
                else                  gap_cnt_n = gap_cnt + 1'b1;
            end
            S_RRES: begin
                if (!reg_cs) begin
                    reg_cs_n    = 1'b1;
                    reg_addr_n  = 4'd9 + {2'b00, k};
                    reg_wr_n    = 1'b0;
                    reg_wdata_n = 32'd0;
                end else if (reg_ack) begin
                    reg_cs_n                     = 1'b0;
                    res_data_n[{k, 5'd0} +: 32]  = reg_rdata;
                    k_n                          = k + 1'b1;
                    if (k == 2'd3) begin
                        res_valid_n = 1'b1;
                        state_n     = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (res_ready) begin
                    res_valid_n = 1'b0;
                    state_n     = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        job_ready_n = (state_n == S_IDLE);
    end

endmodule

// File: tb/tb_aes_reg_master.sv
// tb/tb_aes_reg_master.sv - self-checking bench for aes_reg_master with a behavioural register target

module tb_aes_reg_master;

    localparam int PGAP = 4;
    localparam int PMAX = 4;

    logic         mclk = 1'b0;
    logic         rst_n = 1'b0;
    logic         job_valid = 1'b0;
    logic         job_ready;
    logic [127:0] job_key = '0;
    logic [127:0] job_text = '0;
    logic         job_nokey = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [127:0] res_data;
    logic         res_err;
    logic         busy;
    logic         reg_cs;
    logic [3:0]   reg_addr;
    logic         reg_wr;
    logic [31:0]  reg_wdata;
    logic [3:0]   reg_be;
    logic [31:0]  reg_rdata;
    logic         reg_ack;

    aes_reg_master #(.POLL_GAP(PGAP), .POLL_MAX(PMAX)) dut (
        .mclk(mclk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_key(job_key), .job_text(job_text), .job_nokey(job_nokey),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err), .busy(busy),
        .reg_cs(reg_cs), .reg_addr(reg_addr), .reg_wr(reg_wr),
        .reg_wdata(reg_wdata), .reg_be(reg_be),
        .reg_rdata(reg_rdata), .reg_ack(reg_ack)
    );

    always #5 mclk = ~mclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0]  addr;
        logic        wr;
        logic [31:0] data;
    } acc_t;

    // Behavioural target: acks the cycle after cs, logs every access, clears req after tgt_done polls.
    logic [31:0] tregs [16];
    int          tgt_done = 0;
    int          poll_seen = 0;
    acc_t        acc_log[$];
    logic [31:0] tv;

    always @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            reg_ack   <= 1'b0;
            reg_rdata <= 32'd0;
        end else begin
            reg_ack <= reg_cs && !reg_ack;
            if (reg_cs && !reg_ack) begin
                if (reg_wr) begin
                    tregs[reg_addr] = reg_wdata;
                    if (reg_addr == 4'd0 && reg_wdata[0]) poll_seen = 0;
                    acc_log.push_back('{reg_addr, 1'b1, reg_wdata});
                end else begin
                    if (reg_addr == 4'd0) begin
                        poll_seen++;
                        if (tgt_done != 0 && poll_seen == tgt_done) tregs[0][0] = 1'b0;
                    end
                    tv = tregs[reg_addr];
                    reg_rdata <= tv;
                    acc_log.push_back('{reg_addr, 1'b0, tv});
                end
            end
        end
    end

    // Protocol monitor: cs high exactly 2 cycles; consecutive polls separated by POLL_GAP+1 low cycles.
    logic prev_cs = 1'b0;
    logic last_poll = 1'b0;
    logic is_poll;
    int   hi_len = 0;
    int   lo_len = 0;

    always @(negedge mclk) begin
        if (!rst_n) begin
            prev_cs   = 1'b0;
            last_poll = 1'b0;
            hi_len    = 0;
            lo_len    = 0;
        end else begin
            if (reg_cs) begin
                if (!prev_cs) begin
                    is_poll = (reg_addr == 4'd0) && !reg_wr;
                    if (last_poll && is_poll) chk("poll_gap_low", 128'(lo_len >= PGAP + 1), 128'd1);
                    last_poll = is_poll;
                    hi_len    = 1;
                end else begin
                    hi_len++;
                end
            end else begin
                if (prev_cs) begin
                    chk("cs_high_len", 128'(hi_len), 128'd2);
                    lo_len = 1;
                end else begin
                    lo_len++;
                end
            end
            prev_cs = reg_cs;
        end
    end

    typedef struct {
        logic         nokey;
        logic [127:0] key;
        logic [127:0] text;
        logic [127:0] result;
        int           done_after;
        int           hold;
        logic         exp_err;
        logic [127:0] exp_data;
    } vec_t;

    function automatic logic model_timeout(input int done_after);
        return !(done_after >= 1 && done_after <= PMAX);
    endfunction

    task automatic send_job(input vec_t v);
        int n;
        for (int i = 0; i < 4; i++) tregs[9 + i] = v.result[32*i +: 32];
        tgt_done = v.done_after;
        acc_log.delete();
        @(negedge mclk);
        for (n = 0; n < 200 && !job_ready; n++) @(negedge mclk);
        chk("job_ready_wait", 128'(job_ready), 128'd1);
        job_key   = v.key;
        job_text  = v.text;
        job_nokey = v.nokey;
        job_valid = 1'b1;
        @(posedge mclk);
        #1 job_valid = 1'b0;
    endtask

    task automatic run_job(input vec_t v);
        acc_t         exp_q[$];
        int           npoll, n;
        logic         tmo;
        logic         bus_seen;
        logic [127:0] held;

        if (!v.nokey)
            for (int i = 0; i < 4; i++) exp_q.push_back('{4'(1 + i), 1'b1, v.key[32*i +: 32]});
        for (int i = 0; i < 4; i++) exp_q.push_back('{4'(5 + i), 1'b1, v.text[32*i +: 32]});
        exp_q.push_back('{4'd0, 1'b1, 32'h1});
        tmo   = model_timeout(v.done_after);
        npoll = tmo ? PMAX : v.done_after;
        for (int p = 1; p <= npoll; p++)
            exp_q.push_back('{4'd0, 1'b0, (!tmo && p == npoll) ? 32'h0 : 32'h1});
        if (!tmo)
            for (int i = 0; i < 4; i++) exp_q.push_back('{4'(9 + i), 1'b0, v.result[32*i +: 32]});

        send_job(v);
        for (n = 0; n < 2000 && !res_valid; n++) @(negedge mclk);
        chk("res_valid_wait", 128'(res_valid), 128'd1);

        held     = res_data;
        bus_seen = 1'b0;
        for (int i = 0; i < v.hold; i++) begin
            @(negedge mclk);
            if (reg_cs) bus_seen = 1'b1;
            if (res_data !== held || !res_valid) bus_seen = 1'b1;
        end
        chk("hold_quiet", 128'(bus_seen), 128'd0);
        chk("res_data", res_data, v.exp_data);
        chk("res_err", 128'(res_err), 128'(v.exp_err));

        @(negedge mclk);
        res_ready = 1'b1;
        @(posedge mclk);
        #1 res_ready = 1'b0;
        chk("res_valid_drop", 128'(res_valid), 128'd0);
        chk("busy_after", 128'(busy), 128'd0);

        chk("acc_count", 128'(acc_log.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < acc_log.size(); i++)
            chk($sformatf("acc%0d", i), 128'(acc_log[i]), 128'(exp_q[i]));
    endtask

    vec_t tbl[5];
    vec_t rv;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 16; i++) tregs[i] = 32'd0;

        tbl[0] = '{1'b0, 128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                   128'h69c4e0d86a7b0430d8cdb78070b4c55a, 3, 10,
                   1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        tbl[1] = '{1'b1, 128'h0, 128'hfedcba98765432100123456789abcdef,
                   128'hdeadbeef0badf00dcafef00d12345678, 1, 0,
                   1'b0, 128'hdeadbeef0badf00dcafef00d12345678};
        tbl[2] = '{1'b0, 128'h11112222333344445555666677778888, 128'h99990000aaaabbbbccccddddeeeeffff,
                   128'h0123456789abcdeffedcba9876543210, 4, 2,
                   1'b0, 128'h0123456789abcdeffedcba9876543210};
        tbl[3] = '{1'b0, 128'ha5a5a5a55a5a5a5af0f0f0f00f0f0f0f, 128'h13579bdf2468ace0fdb97531eca86420,
                   128'hffffffffffffffffffffffffffffffff, 0, 3,
                   1'b1, 128'h0};
        tbl[4] = '{1'b1, 128'h0, 128'h0000000100000002000000030000000f,
                   128'h80000000400000002000000010000000, 2, 1,
                   1'b0, 128'h80000000400000002000000010000000};

        // Reset state
        repeat (3) @(negedge mclk);
        chk("rst_cs", 128'(reg_cs), 128'd0);
        chk("rst_res_valid", 128'(res_valid), 128'd0);
        chk("rst_job_ready", 128'(job_ready), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_be", 128'(reg_be), 128'hF);
        rst_n = 1'b1;
        @(posedge mclk);
        #1 chk("job_ready_after_rst", 128'(job_ready), 128'd1);

        for (int i = 0; i < 5; i++) run_job(tbl[i]);

        // Reset while cs is high on text word 2
        rv = tbl[0];
        send_job(rv);
        for (n = 0; n < 200 && !(reg_cs && reg_addr == 4'd7 && reg_wr); n++) @(negedge mclk);
        chk("mid_reset_reach", 128'(reg_cs && reg_addr == 4'd7), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset_cs", 128'(reg_cs), 128'd0);
        chk("mid_reset_busy", 128'(busy), 128'd0);
        chk("mid_reset_res_valid", 128'(res_valid), 128'd0);
        repeat (2) @(negedge mclk);
        rst_n = 1'b1;
        @(posedge mclk);
        #1 chk("mid_reset_job_ready", 128'(job_ready), 128'd1);
        run_job(tbl[0]);

        // Randomized jobs against the access-sequence model
        for (int j = 0; j < 30; j++) begin
            rv.nokey      = 1'($urandom_range(0, 1));
            rv.key        = {$urandom, $urandom, $urandom, $urandom};
            rv.text       = {$urandom, $urandom, $urandom, $urandom};
            rv.result     = {$urandom, $urandom, $urandom, $urandom};
            rv.done_after = $urandom_range(0, PMAX);
            rv.hold       = $urandom_range(0, 10);
            rv.exp_err    = model_timeout(rv.done_after);
            rv.exp_data   = rv.exp_err ? 128'h0 : rv.result;
            run_job(rv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
